// File: rtl/sum_datapath.sv
// sum_datapath: register file plus single-cycle ALU.
// Each cycle the controller presents a control word (op, sh, d, n, m, dw).
// The datapath returns the ALU result and its N/Z/C/V flags combinationally,
// in the same cycle. When dw is high, the result is written back to R[d] on
// the next edge. A separate load port seeds the register file and takes
// priority over the ALU write when both target the same register.
module sum_datapath #(
   parameter int WIDTH = 16,
   parameter int NREGS = 4,
   parameter int RSW   = $clog2(NREGS),
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       op,
   input  logic [SHW-1:0]   sh,
   input  logic [RSW-1:0]   d,
   input  logic [RSW-1:0]   n,
   input  logic [RSW-1:0]   m,
   input  logic             dw,
   input  logic             ld_en,
   input  logic [RSW-1:0]   ld_sel,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] result,
   output logic             cn,
   output logic             cz,
   output logic             cc,
   output logic             cv,
   output logic [3:0]       nzcv_q
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_ORR   = 4'd3;
   localparam logic [3:0] OP_EOR   = 4'd4;
   localparam logic [3:0] OP_B_PAS = 4'd5;
   localparam logic [3:0] OP_A_PAS = 4'd6;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   sum_ext;
   logic             carry;
   logic             ovf;
   logic             op_valid;

   // Operand fetch. B is shifted left with zero fill; bits pushed past the
   // top are discarded.
   always_comb begin
      opa = regs[n];
      opb = regs[m] << sh;
   end

   // ALU. SUB is computed as A + ~B + 1, so the carry-out means "no borrow".
   // Reserved opcodes produce zero and clear every flag, including Z.
   always_comb begin
      result   = '0;
      sum_ext  = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      op_valid = 1'b1;
      unique case (op)
         OP_ADD: begin
            sum_ext = {1'b0, opa} + {1'b0, opb};
            result  = sum_ext[WIDTH-1:0];
            carry   = sum_ext[WIDTH];
            ovf     = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                      (result[WIDTH-1] != opa[WIDTH-1]);
         end
         OP_SUB: begin
            sum_ext = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
            result  = sum_ext[WIDTH-1:0];
            carry   = sum_ext[WIDTH];
            ovf     = (opa[WIDTH-1] != opb[WIDTH-1]) &&
                      (result[WIDTH-1] != opa[WIDTH-1]);
         end
         OP_AND:   result = opa & opb;
         OP_ORR:   result = opa | opb;
         OP_EOR:   result = opa ^ opb;
         OP_B_PAS: result = opb;
         OP_A_PAS: result = opa;
         default:  op_valid = 1'b0;
      endcase
   end

   // Flag outputs, valid in the same cycle as the control word.
   always_comb begin
      cn = op_valid & result[WIDTH-1];
      cz = op_valid & (result == '0);
      cc = carry;
      cv = ovf;
   end

   // Register file and flag register. The load is applied after the ALU
   // write, so it wins when both target the same register. Reset overrides
   // both writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         nzcv_q <= '0;
      end else begin
         if (dw) begin
            regs[d] <= result;
            nzcv_q  <= {cn, cz, cc, cv};
         end
         if (ld_en) begin
            regs[ld_sel] <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_sum_datapath.sv
// Testbench for sum_datapath (WIDTH=16, NREGS=4).
// The bench combines three kinds of stimulus:
//   - directed constant-check vectors,
//   - hand-written multi-cycle sequences,
//   - randomized traffic checked against an arithmetic reference model.
module tb_sum_datapath;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, ORR = 4'd3,
                          EOR = 4'd4, BPAS = 4'd5, APAS = 4'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op;
   logic [3:0]  sh;
   logic [1:0]  d, n, m, ld_sel;
   logic        dw, ld_en;
   logic [15:0] ld_data;
   logic [15:0] result;
   logic        cn, cz, cc, cv;
   logic [3:0]  nzcv_q;

   sum_datapath #(.WIDTH(16), .NREGS(4), .RSW(2), .SHW(4)) dut (
      .clk(clk), .reset(reset), .op(op), .sh(sh), .d(d), .n(n), .m(m),
      .dw(dw), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
      .result(result), .cn(cn), .cz(cz), .cc(cc), .cv(cv), .nzcv_q(nzcv_q)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int mr [4];
   logic [3:0] mq;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  sh;
      logic [15:0] er;
      logic [3:0]  ef;
   } vec_t;
   vec_t vt [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference ALU: plain integer arithmetic on unsigned and signed views.
   function automatic void ref_alu(input int opc, input int a, input int braw, input int s,
                                   output int r, output logic [3:0] f);
      longint b, t;
      int sa, sb, st;
      logic c, v;
      b = (s >= 16) ? 0 : ((longint'(braw) * (longint'(1) << s)) % 65536);
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
      c = 1'b0; v = 1'b0; r = 0; st = 0;
      case (opc)
         0: begin t = a + b; r = int'(t % 65536); c = (t >= 65536);
                  st = sa + sb; v = (st > 32767) || (st < -32768); end
         1: begin t = a - b; r = int'((t + 65536) % 65536); c = (a >= b);
                  st = sa - sb; v = (st > 32767) || (st < -32768); end
         2: r = a & int'(b);
         3: r = a | int'(b);
         4: r = a ^ int'(b);
         5: r = int'(b);
         6: r = a;
         default: r = 0;
      endcase
      f = {r >= 32768, r == 0, c, v};
      if (opc > 6) f = 4'b0000;
   endfunction

   // One clock of stimulus. The task checks the combinational outputs and the
   // registered flags against the model, then advances the model.
   task automatic step(input logic [3:0] o, input int s, input int dd, input int nn, input int mm,
                       input logic w, input logic le, input int ls, input int ldv, input logic rs,
                       output logic [15:0] obs_r, output logic [3:0] obs_f);
      int r;
      logic [3:0] f;
      op = o; sh = s[3:0]; d = dd[1:0]; n = nn[1:0]; m = mm[1:0];
      dw = w; ld_en = le; ld_sel = ls[1:0]; ld_data = ldv[15:0]; reset = rs;
      #1;
      ref_alu(int'(o), mr[nn], mr[mm], s, r, f);
      chk("result", {16'h0, result}, r);
      chk("flags", {28'h0, cn, cz, cc, cv}, {28'h0, f});
      obs_r = result;
      obs_f = {cn, cz, cc, cv};
      @(posedge clk); #1;
      if (rs) begin
         foreach (mr[i]) mr[i] = 0;
         mq = 4'b0000;
      end else begin
         if (w) begin mr[dd] = r; mq = f; end
         if (le) mr[ls] = ldv & 32'hFFFF;
      end
      chk("nzcv_q", {28'h0, nzcv_q}, {28'h0, mq});
   endtask

   task automatic ld(input int sel, input int val);
      logic [15:0] r_o; logic [3:0] f_o;
      step(APAS, 0, 0, 0, 0, 1'b0, 1'b1, sel, val, 1'b0, r_o, f_o);
   endtask

   task automatic read_reg(input int k, input logic [15:0] exp, input string name);
      logic [15:0] r_o; logic [3:0] f_o;
      step(APAS, 0, 0, k, 0, 1'b0, 1'b0, 0, 0, 1'b0, r_o, f_o);
      chk(name, {16'h0, r_o}, {16'h0, exp});
   endtask

   initial begin
      logic [15:0] ro;
      logic [3:0]  fo;
      logic [2:0]  exp_cz;
      int iters;

      vt[0]  = '{ADD,   16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b1001};
      vt[1]  = '{SUB,   16'h0002, 16'h0005, 4'd0,  16'hFFFD, 4'b1000};
      vt[2]  = '{BPAS,  16'h0000, 16'h0001, 4'd3,  16'h0008, 4'b0000};
      vt[3]  = '{BPAS,  16'h0000, 16'h0003, 4'd15, 16'h8000, 4'b1000};
      vt[4]  = '{ADD,   16'hFFFF, 16'h0001, 4'd0,  16'h0000, 4'b0110};
      vt[5]  = '{SUB,   16'h0005, 16'h0005, 4'd0,  16'h0000, 4'b0110};
      vt[6]  = '{SUB,   16'h8000, 16'h0001, 4'd0,  16'h7FFF, 4'b0011};
      vt[7]  = '{AND_,  16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 4'b0000};
      vt[8]  = '{ORR,   16'hF0F0, 16'h0F0F, 4'd0,  16'hFFFF, 4'b1000};
      vt[9]  = '{EOR,   16'hAAAA, 16'hAAAA, 4'd0,  16'h0000, 4'b0100};
      vt[10] = '{APAS,  16'h8001, 16'h0000, 4'd0,  16'h8001, 4'b1000};
      vt[11] = '{4'd9,  16'h1234, 16'h0001, 4'd0,  16'h0000, 4'b0000};
      vt[12] = '{ADD,   16'h8000, 16'h8000, 4'd0,  16'h0000, 4'b0111};
      vt[13] = '{ADD,   16'h0001, 16'h0001, 4'd4,  16'h0011, 4'b0000};

      foreach (mr[i]) mr[i] = 0;
      mq = 4'b0000;
      op = ORR; sh = '0; d = '0; n = '0; m = '0; dw = 1'b0;
      ld_en = 1'b0; ld_sel = '0; ld_data = '0; reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset state
      step(ORR, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, ro, fo);
      chk("rst_result", {16'h0, ro}, 32'h0);
      chk("rst_flags", {28'h0, fo}, 32'h4);
      chk("rst_nzcv_q", {28'h0, nzcv_q}, 32'h0);

      // Directed vectors
      for (int i = 0; i < 14; i++) begin
         ld(0, int'(vt[i].a));
         ld(1, int'(vt[i].b));
         step(vt[i].op, int'(vt[i].sh), 0, 0, 1, 1'b0, 1'b0, 0, 0, 1'b0, ro, fo);
         chk($sformatf("vec%0d_result", i), {16'h0, ro}, {16'h0, vt[i].er});
         chk($sformatf("vec%0d_flags", i), {28'h0, fo}, {28'h0, vt[i].ef});
      end

      // ADD writeback: register value and registered flags
      ld(0, 16'h7FFF); ld(1, 16'h0001);
      step(ADD, 0, 2, 0, 1, 1'b1, 1'b0, 0, 0, 1'b0, ro, fo);
      chk("add_wb_nzcv_q", {28'h0, nzcv_q}, 32'h9);
      read_reg(2, 16'h8000, "add_wb_r2");

      // Summation loop
      ld(0, 3); ld(1, 1); ld(2, 0);
      step(ORR, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, ro, fo);
      chk("sum_orr", {16'h0, ro}, 32'd3);
      exp_cz = 3'b100;
      iters = 0;
      for (int k = 0; k < 8; k++) begin
         step(ADD, 0, 2, 2, 0, 1'b1, 1'b0, 0, 0, 1'b0, ro, fo);
         step(SUB, 0, 0, 0, 1, 1'b1, 1'b0, 0, 0, 1'b0, ro, fo);
         if (k < 3) chk($sformatf("sum_sub%0d_cz", k), {31'h0, fo[2]}, {31'h0, exp_cz[k]});
         iters++;
         if (fo[2]) break;
      end
      chk("sum_iters", iters, 3);
      step(BPAS, 0, 0, 0, 2, 1'b0, 1'b0, 0, 0, 1'b0, ro, fo);
      chk("sum_final", {16'h0, ro}, 32'd6);

      // Simultaneous load and write, same register, then different registers
      ld(0, 16'h7FFF); ld(1, 1); ld(2, 16'h0011); ld(3, 0);
      step(ADD, 0, 2, 0, 1, 1'b1, 1'b1, 2, 16'h00AA, 1'b0, ro, fo);
      chk("simul_same_nzcv_q", {28'h0, nzcv_q}, 32'h9);
      read_reg(2, 16'h00AA, "simul_same_r2");
      ld(2, 16'h0011);
      step(ADD, 0, 3, 0, 1, 1'b1, 1'b1, 2, 16'h00AA, 1'b0, ro, fo);
      chk("simul_diff_nzcv_q", {28'h0, nzcv_q}, 32'h9);
      read_reg(2, 16'h00AA, "simul_diff_r2");
      read_reg(3, 16'h8000, "simul_diff_r3");

      // Mid-sequence reset overrides both load and write
      ld(0, 1); ld(1, 2); ld(2, 3); ld(3, 4);
      step(SUB, 0, 0, 0, 3, 1'b1, 1'b0, 0, 0, 1'b0, ro, fo);
      chk("pre_rst_nzcv_q", {28'h0, nzcv_q}, 32'h8);
      step(ADD, 0, 2, 2, 3, 1'b1, 1'b1, 1, 16'h0055, 1'b1, ro, fo);
      chk("mid_rst_nzcv_q", {28'h0, nzcv_q}, 32'h0);
      for (int k = 0; k < 4; k++) read_reg(k, 16'h0000, $sformatf("mid_rst_r%0d", k));

      // Randomized traffic against the reference model
      for (int k = 0; k < 400; k++) begin
         int o, s, dd, nn, mm, ls, ldv;
         logic w, le, rs;
         o  = $urandom_range(0, 9);
         s  = (($urandom_range(0, 3)) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 3);
         dd = $urandom_range(0, 3);
         nn = $urandom_range(0, 3);
         mm = $urandom_range(0, 3);
         ls = $urandom_range(0, 3);
         case ($urandom_range(0, 3))
            0: ldv = 32'h7FFF;
            1: ldv = 32'h8000 + $urandom_range(0, 1);
            default: ldv = $urandom_range(0, 65535);
         endcase
         w  = ($urandom_range(0, 1) == 1);
         le = ($urandom_range(0, 2) == 0);
         rs = ($urandom_range(0, 39) == 0);
         step(o[3:0], s, dd, nn, mm, w, le, ls, ldv, rs, ro, fo);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
